// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues Wishbone-classic reads,
// buffers responses in a DEPTH-entry prefetch FIFO and presents the head entry
// to decode over a valid/ready handshake. Redirects flush the FIFO and kill any
// in-flight response. Misaligned PCs and bus errors become exception entries.
module if_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_instruction_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_add4_o,
    output logic        id_exc_addr_o,
    output logic        id_exc_bus_o,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic          halted_reg, halted_next;
    logic [AW:0]   cnt_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;

    logic          push, pop, flush, bus_done;
    logic [31:0]   push_instr;
    logic          push_exc_addr, push_exc_bus;

    logic [31:0]   instr_mem    [DEPTH];
    logic [31:0]   pc_mem       [DEPTH];
    logic          exc_addr_mem [DEPTH];
    logic          exc_bus_mem  [DEPTH];

    assign bus_done = iwbm_ack_i || iwbm_err_i;

    // Head-of-FIFO view for decode; exception flags are masked while empty.
    assign id_valid_o       = (cnt_reg != '0);
    assign id_instruction_o = instr_mem[rd_ptr_reg];
    assign id_pc_o          = pc_mem[rd_ptr_reg];
    assign id_pc_add4_o     = pc_mem[rd_ptr_reg] + 32'd4;
    assign id_exc_addr_o    = id_valid_o && exc_addr_mem[rd_ptr_reg];
    assign id_exc_bus_o     = id_valid_o && exc_bus_mem[rd_ptr_reg];

    // Bus is driven straight from registers; a request is live in REQ and DISCARD.
    assign iwbm_cyc_o  = (state_reg != ST_IDLE);
    assign iwbm_stb_o  = (state_reg != ST_IDLE);
    assign iwbm_addr_o = addr_reg;

    // Fetch FSM, push/pop decisions and redirect override.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        addr_next     = addr_reg;
        halted_next   = halted_reg;
        push          = 1'b0;
        push_instr    = NOP;
        push_exc_addr = 1'b0;
        push_exc_bus  = 1'b0;
        flush         = 1'b0;
        pop           = id_valid_o && id_ready_i;

        case (state_reg)
            ST_IDLE: begin
                if (!halted_reg && (cnt_reg < DEPTH_W)) begin
                    if (pc_reg[1:0] == 2'b00) begin
                        state_next = ST_REQ;
                        addr_next  = pc_reg;
                    end else begin
                        push          = 1'b1;
                        push_exc_addr = 1'b1;
                        halted_next   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (iwbm_ack_i) begin
                    push       = 1'b1;
                    push_instr = iwbm_dat_i;
                    pc_next    = pc_reg + 32'd4;
                    // The ack consumes the reserved slot; continue only if
                    // another slot is still free after this cycle's push/pop.
                    if (pop || (cnt_reg < DEPTH_M1)) begin
                        addr_next = pc_reg + 32'd4;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (iwbm_err_i) begin
                    push         = 1'b1;
                    push_exc_bus = 1'b1;
                    halted_next  = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (bus_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (redirect_i) begin
            flush       = 1'b1;
            push        = 1'b0;
            pop         = 1'b0;
            pc_next     = redirect_addr_i;
            halted_next = 1'b0;
            addr_next   = addr_reg;
            case (state_reg)
                // A classic cycle cannot be abandoned, so an unanswered
                // request is held until its response and then dropped.
                ST_REQ, ST_DISCARD: state_next = bus_done ? ST_IDLE : ST_DISCARD;
                default: begin
                    // Bus idle: start the new fetch immediately when aligned.
                    if (redirect_addr_i[1:0] == 2'b00) begin
                        state_next = ST_REQ;
                        addr_next  = redirect_addr_i;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Control state, fetch PC and FIFO bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_ADDR;
            addr_reg   <= RESET_ADDR;
            halted_reg <= 1'b0;
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            addr_reg   <= addr_next;
            halted_reg <= halted_next;
            if (flush) begin
                cnt_reg    <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + (AW+1)'(push) - (AW+1)'(pop);
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
        end
    end

    // FIFO storage; entry PC equals the fetch PC in every pushing state.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_reg]    <= push_instr;
            pc_mem[wr_ptr_reg]       <= pc_reg;
            exc_addr_mem[wr_ptr_reg] <= push_exc_addr;
            exc_bus_mem[wr_ptr_reg]  <= push_exc_bus;
        end
    end
endmodule
